div_seq: RTL and testbench

Iterative divide sequencer for the RV32IM five-stage pipeline. It accepts DIV/DIVU/REM/REMU operations from the execute stage and runs a radix-2 restoring division over 32 iterations. It holds a stall request so the hazard unit freezes fetch, decode and the ID/EX register (enable = ~StallE) and bubbles EX/MEM until the result is ready. It then presents the result for exactly one cycle while the instruction is still in EX.

---
 rtl/div_seq_if.sv | 24 ++
 rtl/div_seq.sv | 125 ++++++++++++
 tb/tb_div_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Execute-stage <-> divide sequencer signal bundle.
// The master side is the execute stage; the slave side is the divider.
interface div_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            StartE;
  logic [1:0]      DivOpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            KillE;
  logic            StallReqE;
  logic            DoneE;
  logic [XLEN-1:0] ResultE;

  modport master (
    output StartE, DivOpE, SrcAE, SrcBE, KillE,
    input  StallReqE, DoneE, ResultE
  );

  modport slave (
    input  StartE, DivOpE, SrcAE, SrcBE, KillE,
    output StallReqE, DoneE, ResultE
  );
endinterface

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// It stalls the pipeline and pulses DoneE for one cycle while the instruction is still in EX.
module div_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  div_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [1:0]      op;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] result;
  logic            done_r;

  logic            start;
  logic            signed_in;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] trial;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  always_comb begin
    start     = (state == IDLE) && bus.StartE && !bus.KillE;
    signed_in = ~bus.DivOpE[0];
    div_zero  = (bus.SrcBE == '0);
    overflow  = signed_in && (bus.SrcAE == MIN_NEG) && (bus.SrcBE == '1);
    abs_a     = (signed_in && bus.SrcAE[XLEN-1]) ? -bus.SrcAE : bus.SrcAE;
    abs_b     = (signed_in && bus.SrcBE[XLEN-1]) ? -bus.SrcBE : bus.SrcBE;
    // Trial subtract carries one extra bit so the borrow is always visible.
    rem_sh    = {rem[XLEN-1:0], quo[XLEN-1]};
    trial     = {1'b0, rem_sh} - {2'b00, dvs};
    q_fix     = (~op[0] && (sign_a ^ sign_b)) ? -quo : quo;
    r_fix     = (~op[0] && sign_a) ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      quo    <= '0;
      dvs    <= '0;
      rem    <= '0;
      result <= '0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op     <= bus.DivOpE;
            sign_a <= signed_in & bus.SrcAE[XLEN-1];
            sign_b <= signed_in & bus.SrcBE[XLEN-1];
            quo    <= abs_a;
            dvs    <= abs_b;
            rem    <= '0;
            count  <= CW'(XLEN-1);
            if (div_zero) begin
              result <= bus.DivOpE[1] ? bus.SrcAE : '1;
              done_r <= 1'b1;
              state  <= DONE;
            end else if (overflow) begin
              result <= bus.DivOpE[1] ? '0 : MIN_NEG;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.KillE) begin
            state <= IDLE;
          end else begin
            if (!trial[XLEN+1]) begin
              rem <= trial[XLEN:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= rem_sh;
              quo <= {quo[XLEN-2:0], 1'b0};
            end
            count <= count - 1'b1;
            if (count == '0) state <= FIX;
          end
        end
        FIX: begin
          if (bus.KillE) begin
            state <= IDLE;
          end else begin
            result <= op[1] ? r_fix : q_fix;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // StartE seen here belongs to the instruction just completed.
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.StallReqE = reset_n &&
                         (start || (((state == RUN) || (state == FIX)) && !bus.KillE));
  assign bus.DoneE     = done_r && !bus.KillE;
  assign bus.ResultE   = result;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: results, stall lengths, fast paths, back-to-back, kill and reset.
module tb_div_seq;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  div_seq_if #(.XLEN(32)) bus ();

  div_seq #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Start an op at the next cycle and follow it until DoneE; StartE stays high through DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
    int   stalls;
    logic got_done;
    logic done_stall;
    logic [31:0] res;
    stalls = 0; got_done = 1'b0; done_stall = 1'b1; res = '0;
    @(posedge clk); #1;
    bus.StartE = 1'b1; bus.KillE = 1'b0;
    bus.DivOpE = op; bus.SrcAE = a; bus.SrcBE = b;
    for (int c = 0; c < 60 && !got_done; c++) begin
      @(negedge clk);
      if (bus.DoneE === 1'b1) begin
        got_done   = 1'b1;
        done_stall = bus.StallReqE;
        res        = bus.ResultE;
      end else if (bus.StallReqE === 1'b1) begin
        stalls++;
      end
      if (c == 1) begin
        bus.SrcAE  = $urandom;
        bus.SrcBE  = $urandom;
        bus.DivOpE = ~op;
      end
    end
    check({tag, " done_seen"}, 32'(got_done), 32'd1);
    check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({tag, " stall_in_done"}, 32'(done_stall), 32'd0);
    check({tag, " result"}, res, exp_res);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    @(negedge clk);
    check({tag, " idle_done"}, 32'(bus.DoneE), 32'd0);
    check({tag, " idle_stall"}, 32'(bus.StallReqE), 32'd0);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int dones;
    int stalls;
    dones = 0; stalls = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.DoneE !== 1'b0) dones++;
      if (bus.StallReqE !== 1'b0) stalls++;
    end
    check({tag, " extra_done"}, 32'(dones), 32'd0);
    check({tag, " extra_stall"}, 32'(stalls), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    bus.StartE = 1'b1;
    bus.KillE  = 1'b0;
    bus.DivOpE = OP_DIVU;
    bus.SrcAE  = 32'd100;
    bus.SrcBE  = 32'd7;
    #2;
    check("reset stall", 32'(bus.StallReqE), 32'd0);
    check("reset done", 32'(bus.DoneE), 32'd0);
    check("reset result", bus.ResultE, 32'd0);
    bus.StartE = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);           idle_check("divu 100/7");
    run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);            idle_check("remu 100/7");
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34); idle_check("div -7/2");
    run_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34); idle_check("rem -7/2");
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34); idle_check("div 7/-2");
    run_op("div -7/-2", OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 34);
    idle_check("div -7/-2");
    run_op("rem -7/-2", OP_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34);
    idle_check("rem -7/-2");
    run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);         idle_check("divu 5/0");
    run_op("rem 5/0", OP_REM, 32'd5, 32'd0, 32'd5, 1);                   idle_check("rem 5/0");
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    idle_check("div ovf");
    run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);   idle_check("rem ovf");
    run_op("divu big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    idle_check("divu big");
    run_op("remu big", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    idle_check("remu big");

    run_op("b2b first", OP_DIVU, 32'd1000, 32'd10, 32'd100, 34);
    run_op("b2b second", OP_DIVU, 32'd12345, 32'd100, 32'd123, 34);
    idle_check("b2b");
    watch_quiet("b2b", 40);

    // Kill in the tenth RUN cycle.
    @(posedge clk); #1;
    bus.StartE = 1'b1; bus.DivOpE = OP_DIVU; bus.SrcAE = 32'd100; bus.SrcBE = 32'd7;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("kill pre stall", 32'(bus.StallReqE), 32'd1);
    @(posedge clk); #1;
    bus.KillE = 1'b1;
    @(negedge clk);
    check("kill stall", 32'(bus.StallReqE), 32'd0);
    check("kill done", 32'(bus.DoneE), 32'd0);
    @(posedge clk); #1;
    bus.KillE = 1'b0; bus.StartE = 1'b0;
    watch_quiet("kill", 45);
    check("kill result kept", bus.ResultE, 32'd123);

    // Reset in the twentieth RUN cycle, with StartE still high.
    @(posedge clk); #1;
    bus.StartE = 1'b1; bus.DivOpE = OP_DIVU; bus.SrcAE = 32'hFFFF_FFFF; bus.SrcBE = 32'd1;
    repeat (20) @(posedge clk);
    #1;
    check("rst pre stall", 32'(bus.StallReqE), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst stall", 32'(bus.StallReqE), 32'd0);
    check("rst done", 32'(bus.DoneE), 32'd0);
    check("rst result", bus.ResultE, 32'd0);
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst release stall", 32'(bus.StallReqE), 32'd0);
    check("rst release done", 32'(bus.DoneE), 32'd0);
    watch_quiet("rst", 40);

    run_op("post rst divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    idle_check("post rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
